// File: rtl/vga_scan_out.sv
// 640x480@60 VGA scan-out: pops one FIFO pixel per 8-column span, replicates it
// horizontally, and drives registered RGB/sync/blank after a two-stage pipeline.
module vga_scan_out #(
    parameter int unsigned H_ACTIVE        = 640,
    parameter int unsigned H_FP            = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BP            = 48,
    parameter int unsigned V_ACTIVE        = 480,
    parameter int unsigned V_FP            = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BP            = 33,
    parameter logic [23:0] UNDERFLOW_COLOR = 24'hFF00FF
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        rd_en,
    input  logic [23:0] fifo_data,
    input  logic        fifo_empty,
    input  logic        fifo_full,
    output logic        hsync,
    output logic        vsync,
    output logic        blank_n,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        underflow
);

    localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_ON  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SYNC_OFF = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_ON  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SYNC_OFF = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    typedef enum logic {WAIT, RUN} state_t;

    state_t      state;
    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        run;
    logic        active;
    logic        hs;
    logic        vs;
    logic        fetch;
    logic        act_d1;
    logic        hs_d1;
    logic        vs_d1;
    logic        fetch_d1;
    logic        load_d1;
    logic [23:0] hold;

    // Decode is gated by RUN so WAIT feeds the pipeline blank, syncs-high values.
    always_comb begin
        run    = (state == RUN);
        active = run && (h_cnt < H_VIS) && (v_cnt < V_VIS);
        hs     = !(run && (h_cnt >= H_SYNC_ON) && (h_cnt < H_SYNC_OFF));
        vs     = !(run && (v_cnt >= V_SYNC_ON) && (v_cnt < V_SYNC_OFF));
        fetch  = active && (h_cnt[2:0] == 3'd0);
        rd_en  = fetch && !fifo_empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WAIT;
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            case (state)
                WAIT: begin
                    if (fifo_full) state <= RUN;
                end
                RUN: begin
                    if (h_cnt == H_LAST) begin
                        h_cnt <= '0;
                        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
                    end else begin
                        h_cnt <= h_cnt + 10'd1;
                    end
                end
                default: state <= WAIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_d1    <= 1'b0;
            hs_d1     <= 1'b1;
            vs_d1     <= 1'b1;
            fetch_d1  <= 1'b0;
            load_d1   <= 1'b0;
            hsync     <= 1'b1;
            vsync     <= 1'b1;
            blank_n   <= 1'b0;
            red       <= '0;
            green     <= '0;
            blue      <= '0;
            hold      <= '0;
            underflow <= 1'b0;
        end else begin
            act_d1   <= active;
            hs_d1    <= hs;
            vs_d1    <= vs;
            fetch_d1 <= fetch;
            load_d1  <= rd_en;

            hsync   <= hs_d1;
            vsync   <= vs_d1;
            blank_n <= act_d1;

            // A skipped fetch paints its whole span in the underflow colour via hold.
            if (act_d1) begin
                if (load_d1)
                    {red, green, blue} <= fifo_data;
                else if (fetch_d1)
                    {red, green, blue} <= UNDERFLOW_COLOR;
                else
                    {red, green, blue} <= hold;
            end else begin
                {red, green, blue} <= '0;
            end

            if (load_d1)
                hold <= fifo_data;
            else if (fetch_d1)
                hold <= UNDERFLOW_COLOR;

            if (fetch && fifo_empty)
                underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// Bench for vga_scan_out on a shrunken raster so whole frames fit in a short run;
// a span-level reference model predicts every output each cycle.
module tb_vga_scan_out;

    localparam int HA = 64, HF = 8, HS = 12, HB = 20;
    localparam int HT = HA + HF + HS + HB;
    localparam int VA = 20, VF = 3, VS = 2, VB = 5;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam logic [23:0] UF = 24'hFF00FF;

    typedef struct packed {
        logic        act;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } vis_t;
    localparam vis_t IDLE = '{1'b0, 1'b1, 1'b1, 24'h000000};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en;
    logic [23:0] fifo_data = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_full = 1'b0;
    logic        hsync, vsync, blank_n, underflow;
    logic [7:0]  red, green, blue;

    vga_scan_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .UNDERFLOW_COLOR(UF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .fifo_data(fifo_data),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .hsync(hsync),
        .vsync(vsync), .blank_n(blank_n), .red(red), .green(green),
        .blue(blue), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int          vecs = 0, errs = 0;
    bit          running = 0, pop_prev = 0, uf_exp = 0, refill = 0;
    int          n = 0, force_n = -1;
    logic [23:0] q[$];
    logic [23:0] popped = '0, span_col = '0;
    vis_t        p1 = IDLE, p2 = IDLE;
    int          line_pops = 0, frame_pops = 0, line_miss = 0, frame_miss = 0;
    int          hs_low = 0, vs_low = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vecs++;
        assert (obs === want) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // One pixel clock: inputs change 1 time unit after the edge, outputs are checked on the falling edge.
    task automatic cycle(input bit full_val, input bit rst_val);
        int   h, v;
        bit   act, fetch, empty;
        vis_t cur;
        @(posedge clk);
        if (running) n++;
        else if (rst_n && fifo_full) begin running = 1; n = 0; end
        #1;
        rst_n     = rst_val;
        fifo_data = pop_prev ? popped
                  : (($urandom % 4 == 0) ? 24'hFFFFFF : 24'($urandom));
        h     = n % HT;
        v     = (n / HT) % VT;
        act   = running && h < HA && v < VA;
        fetch = act && (h % 8 == 0);
        empty = (running && n == force_n) || (q.size() == 0);
        fifo_full  = full_val;
        fifo_empty = empty;
        pop_prev   = fetch && !empty;
        if (pop_prev) begin
            popped   = q.pop_front();
            span_col = popped;
        end else if (fetch) begin
            span_col = UF;
            line_miss++;
            frame_miss++;
        end
        while (refill && q.size() < 4) q.push_back(24'($urandom));
        cur.act = act;
        cur.hs  = !(running && h >= HA + HF && h < HA + HF + HS);
        cur.vs  = !(running && v >= VA + VF && v < VA + VF + VS);
        cur.rgb = act ? span_col : 24'h0;

        @(negedge clk);
        chk("rd_en", 32'(rd_en), 32'(pop_prev));
        chk("underflow", 32'(underflow), 32'(uf_exp));
        chk("blank_n", 32'(blank_n), 32'(p2.act));
        chk("hsync", 32'(hsync), 32'(p2.hs));
        chk("vsync", 32'(vsync), 32'(p2.vs));
        chk("rgb", {8'h0, red, green, blue}, {8'h0, p2.rgb});
        p2 = p1;
        p1 = cur;
        if (fetch && empty) uf_exp = 1;

        if (rd_en) begin line_pops++; frame_pops++; end
        if (!hsync) hs_low++;
        else if (hs_low != 0) begin chk("hsync_width", 32'(hs_low), 32'(HS)); hs_low = 0; end
        if (!vsync) vs_low++;
        else if (vs_low != 0) begin chk("vsync_width", 32'(vs_low), 32'(VS * HT)); vs_low = 0; end
        if (running && h == HT - 1) begin
            chk("line_pops", 32'(line_pops), 32'((v < VA) ? HA / 8 - line_miss : 0));
            line_pops = 0;
            line_miss = 0;
        end
        if (running && n % FT == FT - 1) begin
            chk("frame_pops", 32'(frame_pops), 32'(VA * HA / 8 - frame_miss));
            frame_pops = 0;
            frame_miss = 0;
        end
    endtask

    task automatic clear_model();
        running = 0; pop_prev = 0; uf_exp = 0; n = 0; force_n = -1;
        p1 = IDLE; p2 = IDLE;
        line_pops = 0; frame_pops = 0; line_miss = 0; frame_miss = 0;
        hs_low = 0; vs_low = 0;
    endtask

    initial begin
        clear_model();
        repeat (3) cycle(1'b0, 1'b0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        repeat (100) cycle(1'b0, 1'b1);

        // Prime with two known pixels, then keep the FIFO topped up with random data.
        q.push_back(24'h123456);
        q.push_back(24'hABCDEF);
        refill = 1;
        cycle(1'b1, 1'b1);
        force_n = FT + 10 * HT + 32;
        while (!(running && n == 2 * FT + 15 * HT + 20))
            cycle(1'($urandom_range(1, 0)), 1'b1);

        // Asynchronous reset mid-line: outputs must drop before any clock edge.
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_rd_en", 32'(rd_en), 32'd0);
        chk("midrst_hsync", 32'(hsync), 32'd1);
        chk("midrst_vsync", 32'(vsync), 32'd1);
        chk("midrst_blank_n", 32'(blank_n), 32'd0);
        chk("midrst_rgb", {8'h0, red, green, blue}, 32'd0);
        chk("midrst_underflow", 32'(underflow), 32'd0);
        clear_model();
        repeat (3) cycle(1'b1, 1'b0);
        repeat (20) cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        repeat (3 * HT + 10) cycle(1'($urandom_range(1, 0)), 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
